// File: rtl/addsub_pipe_stream.sv
// Pipelined add/subtract with ripple carry split across stages, optional
// saturation, signed/unsigned overflow detection and a valid/ready stream
// interface. One DATAWIDTH/NUM_PIPELINE_STAGES wide result slice is computed
// per stage; the carry out of each slice is registered into the next stage.
module addsub_pipe_stream #(
   parameter int DATAWIDTH           = 16,
   parameter int NUM_PIPELINE_STAGES = 4,
   parameter int INSTANCE_ID         = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_valid,
   output logic                 i_ready,
   input  logic [DATAWIDTH-1:0] A,
   input  logic [DATAWIDTH-1:0] B,
   input  logic [1:0]           op,
   input  logic                 signed_mode,
   output logic [DATAWIDTH-1:0] Result,
   output logic                 carry_borrow,
   output logic                 overflow,
   output logic                 o_valid,
   input  logic                 o_ready,
   output logic [15:0]          ovf_count
);

   localparam int S = NUM_PIPELINE_STAGES;
   localparam int W = DATAWIDTH / NUM_PIPELINE_STAGES;

   // Slices must tile the word exactly; ids are non-negative labels only.
   if ((DATAWIDTH % NUM_PIPELINE_STAGES) != 0 || NUM_PIPELINE_STAGES < 1 ||
       NUM_PIPELINE_STAGES > DATAWIDTH || INSTANCE_ID < 0) begin : g_bad_params
      $error("addsub_pipe_stream: illegal parameter combination");
   end

   // Clamp the wrapped result to the range limit when saturation is requested.
   function automatic logic [DATAWIDTH-1:0] saturate(
      input logic [DATAWIDTH-1:0] raw,
      input logic                 ovf,
      input logic                 sat_en,
      input logic                 sub,
      input logic                 sgn,
      input logic                 a_msb
   );
      logic [DATAWIDTH-1:0] r;
      r = raw;
      if (sat_en && ovf) begin
         if (sgn) begin
            r = a_msb ? {1'b1, {(DATAWIDTH-1){1'b0}}} : {1'b0, {(DATAWIDTH-1){1'b1}}};
         end else begin
            r = sub ? '0 : '1;
         end
      end
      return r;
   endfunction

   // Stage registers: operands travel with the transaction, res_p holds the
   // slices finished so far, cy_p the carry out of the newest slice and cm_p
   // the carry into that slice's top bit (meaningful in the last stage).
   logic [DATAWIDTH-1:0] a_p   [S];
   logic [DATAWIDTH-1:0] b_p   [S];
   logic [DATAWIDTH-1:0] res_p [S];
   logic                 cy_p  [S];
   logic                 cm_p  [S];
   logic [1:0]           op_p  [S];
   logic                 sm_p  [S];
   logic                 vld_p [S];

   logic [DATAWIDTH-1:0] a_src   [S];
   logic [DATAWIDTH-1:0] b_src   [S];
   logic [DATAWIDTH-1:0] r_src   [S];
   logic [DATAWIDTH-1:0] r_nx    [S];
   logic                 cy_src  [S];
   logic                 cy_nx   [S];
   logic                 cm_nx   [S];
   logic [1:0]           op_src  [S];
   logic                 sm_src  [S];
   logic                 vld_src [S];
   logic [W:0]           sum;
   logic                 advance;

   assign advance = o_ready | ~o_valid;
   assign i_ready = advance;

   // Stage inputs and the slice each stage adds on its way into its register.
   always_comb begin
      a_src[0]   = A;
      b_src[0]   = op[0] ? ~B : B;
      r_src[0]   = '0;
      cy_src[0]  = op[0];
      op_src[0]  = op;
      sm_src[0]  = signed_mode;
      vld_src[0] = i_valid;
      for (int s = 1; s < S; s++) begin
         a_src[s]   = a_p[s-1];
         b_src[s]   = b_p[s-1];
         r_src[s]   = res_p[s-1];
         cy_src[s]  = cy_p[s-1];
         op_src[s]  = op_p[s-1];
         sm_src[s]  = sm_p[s-1];
         vld_src[s] = vld_p[s-1];
      end
      sum = '0;
      for (int s = 0; s < S; s++) begin
         sum = {1'b0, a_src[s][s*W +: W]} + {1'b0, b_src[s][s*W +: W]} + {{W{1'b0}}, cy_src[s]};
         r_nx[s]            = r_src[s];
         r_nx[s][s*W +: W]  = sum[W-1:0];
         cy_nx[s]           = sum[W];
         cm_nx[s]           = a_src[s][s*W+W-1] ^ b_src[s][s*W+W-1] ^ sum[W-1];
      end
   end

   // Whole pipeline shifts together only when the output side can move.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int s = 0; s < S; s++) begin
            a_p[s]   <= '0;
            b_p[s]   <= '0;
            res_p[s] <= '0;
            cy_p[s]  <= 1'b0;
            cm_p[s]  <= 1'b0;
            op_p[s]  <= '0;
            sm_p[s]  <= 1'b0;
            vld_p[s] <= 1'b0;
         end
      end else if (advance) begin
         for (int s = 0; s < S; s++) begin
            a_p[s]   <= a_src[s];
            b_p[s]   <= b_src[s];
            res_p[s] <= r_nx[s];
            cy_p[s]  <= cy_nx[s];
            cm_p[s]  <= cm_nx[s];
            op_p[s]  <= op_src[s];
            sm_p[s]  <= sm_src[s];
            vld_p[s] <= vld_src[s];
         end
      end
   end

   // Output stage: flags and saturation come straight from the last registers.
   assign o_valid      = vld_p[S-1];
   assign carry_borrow = cy_p[S-1];
   assign overflow     = sm_p[S-1] ? (cm_p[S-1] ^ cy_p[S-1]) : (cy_p[S-1] ^ op_p[S-1][0]);
   assign Result       = saturate(res_p[S-1], overflow, op_p[S-1][1], op_p[S-1][0],
                                  sm_p[S-1], a_p[S-1][DATAWIDTH-1]);

   // Count delivered overflowing transactions, sticking at the top value.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ovf_count <= '0;
      end else if (o_valid && o_ready && overflow && (ovf_count != 16'hFFFF)) begin
         ovf_count <= ovf_count + 16'd1;
      end
   end

endmodule
